// File: rtl/instr_prefetch_pkg.sv
// Shared constants and sizing helpers for the instruction prefetcher.
package instr_prefetch_pkg;

    localparam int WORD_BYTES = 32'd4;

    function automatic int bus_wid(input int bus_len);
        return 32'd32 * bus_len;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO with registered storage, simultaneous push/pop and a flush that wins over pop.
module instr_prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Push is allowed when full only if the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop_i & (cnt_q != '0);
        do_push_s = push_i & ((cnt_q != CW'(DEPTH)) | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_prefetch.sv
// Multi-outstanding instruction prefetcher with kill counting on redirect and stop-on-error.
// Optional INSTR_PREFETCH_PC_EN adds instr_pc, carried through a per-request tag queue.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              BUS_LEN  = 2,
    parameter int              OUTSTD   = 4,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             BUS_WID  = bus_wid(BUS_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_req_ack,
    input  logic [BUS_WID-1:0] imem_rdata,
    input  logic               imem_resp,
    input  logic               imem_err,
    input  logic               jump_vld,
    input  logic [XLEN-1:0]    jump_pc,
    input  logic               branch_vld,
    input  logic [XLEN-1:0]    branch_pc,
    output logic               instr_vld,
    output logic [BUS_WID-1:0] instr_data,
    output logic               instr_err,
`ifdef INSTR_PREFETCH_PC_EN
    output logic [XLEN-1:0]    instr_pc,
`endif
    input  logic               instr_rdy
);

    localparam int              CW         = cnt_width(QDEPTH);
    localparam int              BEAT_BYTES = WORD_BYTES * BUS_LEN;
    localparam logic [XLEN-1:0] BEAT_MASK  = XLEN'(BEAT_BYTES - 1);
`ifdef INSTR_PREFETCH_PC_EN
    localparam int              EW         = XLEN + 1 + BUS_WID;
    localparam int              TW         = cnt_width(OUTSTD);
`else
    localparam int              EW         = 1 + BUS_WID;
`endif

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
    logic            err_hold_q, err_hold_d;
    logic            reload_vld_s, accept_s, live_s, pop_s;
    logic [XLEN-1:0] reload_pc_s, fetch_addr_s;
    logic [CW:0]     occ_s;
    logic [CW-1:0]   fifo_cnt_s;
    logic [EW-1:0]   push_data_s, head_s;

    assign reload_vld_s = jump_vld | branch_vld;
    assign reload_pc_s  = (jump_vld ? jump_pc : branch_pc) & ~XLEN'(1);
    assign fetch_addr_s = reload_vld_s ? reload_pc_s : pc_q;
    assign imem_addr    = fetch_addr_s & ~BEAT_MASK;

    // Reservation: every in-flight request already owns a FIFO slot; a reload frees the whole FIFO.
    assign occ_s    = {1'b0, out_cnt_q} + (reload_vld_s ? {(CW+1){1'b0}} : {1'b0, fifo_cnt_s});
    assign imem_req = (out_cnt_q < CW'(OUTSTD)) & (occ_s < (CW+1)'(QDEPTH))
                    & (~err_hold_q | reload_vld_s);

    assign accept_s  = imem_req & imem_req_ack;
    assign live_s    = imem_resp & (kill_cnt_q == '0) & ~reload_vld_s;
    assign pop_s     = instr_vld & instr_rdy & ~reload_vld_s;
    assign out_cnt_d = out_cnt_q + CW'(accept_s) - CW'(imem_resp);

    // Next fetch pc, kill counter and error hold.
    always_comb begin
        pc_d       = pc_q;
        kill_cnt_d = kill_cnt_q;
        err_hold_d = err_hold_q;
        if (accept_s) begin
            pc_d = imem_addr + XLEN'(BEAT_BYTES);
        end else if (reload_vld_s) begin
            pc_d = reload_pc_s;
        end else begin
            pc_d = pc_q;
        end
        if (reload_vld_s) begin
            kill_cnt_d = out_cnt_q - CW'(imem_resp);
            err_hold_d = 1'b0;
        end else if (imem_resp && (kill_cnt_q != '0)) begin
            kill_cnt_d = kill_cnt_q - CW'(1);
        end else if (live_s && imem_err) begin
            // Includes a request accepted in this very cycle: nothing after an error is wanted.
            kill_cnt_d = out_cnt_d;
            err_hold_d = 1'b1;
        end else begin
            kill_cnt_d = kill_cnt_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            kill_cnt_q <= '0;
            err_hold_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            kill_cnt_q <= kill_cnt_d;
            err_hold_q <= err_hold_d;
        end
    end

`ifdef INSTR_PREFETCH_PC_EN
    logic [XLEN-1:0] tag_head_s;
    logic [TW-1:0]   tag_cnt_s;

    // Stale responses still pop their tags, so a redirect drains this queue without a flush.
    instr_prefetch_fifo #(.WIDTH(XLEN), .DEPTH(OUTSTD)) u_tag_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept_s),
        .push_data_i (fetch_addr_s),
        .pop_i       (imem_resp & (tag_cnt_s != '0)),
        .flush_i     (1'b0),
        .count_o     (tag_cnt_s),
        .head_o      (tag_head_s)
    );

    assign push_data_s = {tag_head_s, imem_err, imem_rdata};
    assign instr_pc    = head_s[EW-1 -: XLEN];
`else
    assign push_data_s = {imem_err, imem_rdata};
`endif

    instr_prefetch_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_data_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (live_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (reload_vld_s),
        .count_o     (fifo_cnt_s),
        .head_o      (head_s)
    );

    assign instr_vld  = (fifo_cnt_s != '0);
    assign instr_data = head_s[BUS_WID-1:0];
    assign instr_err  = head_s[BUS_WID] & instr_vld;

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench for instr_prefetch against a queue-based model of outstanding requests and queued beats.
module tb_instr_prefetch;

    localparam int XLEN   = 32;
    localparam int OUTSTD = 4;
    localparam int QDEPTH = 4;
    localparam int BEAT   = 8;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_req_ack = 1'b0;
    logic [63:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        imem_err = 1'b0;
    logic        jump_vld = 1'b0;
    logic [31:0] jump_pc = '0;
    logic        branch_vld = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        instr_vld;
    logic [63:0] instr_data;
    logic        instr_err;
    logic        instr_rdy = 1'b0;
`ifdef INSTR_PREFETCH_PC_EN
    logic [31:0] instr_pc;
`endif

    always #5 clk = ~clk;

    instr_prefetch #(.XLEN(XLEN), .BUS_LEN(2), .OUTSTD(OUTSTD), .QDEPTH(QDEPTH), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .imem_err     (imem_err),
        .jump_vld     (jump_vld),
        .jump_pc      (jump_pc),
        .branch_vld   (branch_vld),
        .branch_pc    (branch_pc),
        .instr_vld    (instr_vld),
        .instr_data   (instr_data),
        .instr_err    (instr_err),
`ifdef INSTR_PREFETCH_PC_EN
        .instr_pc     (instr_pc),
`endif
        .instr_rdy    (instr_rdy)
    );

    typedef struct packed { logic [31:0] pc; logic stale; } req_t;
    typedef struct packed { logic [31:0] pc; logic err; logic [63:0] data; } beat_t;
    typedef struct packed { int due; logic err; logic [63:0] data; } bus_t;

    req_t  oq[$];   // accepted, unanswered requests
    beat_t fq[$];   // beats the consumer should see, in order
    bus_t  bq[$];   // bus responses scheduled
    logic [31:0] m_pc;
    bit          m_err_hold;
    int          cyc, last_due;
    int          n_checks, n_fail, n_acc;
    int          p_ack, p_rdy, p_jmp, p_br, p_err, lat_min, lat_max;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {jump_vld, branch_vld, imem_resp, imem_err, imem_req_ack, instr_rdy} = '0;
        repeat (2) @(posedge clk);
        oq.delete(); fq.delete(); bq.delete();
        m_pc = RST_PC; m_err_hold = 1'b0; last_due = cyc;
    endtask

    function automatic bit roll(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic cycle();
        bit          reload, ereq, evld, acc, resp, live, pop, jv, bv;
        logic [31:0] rpc, fa, ea;
        req_t        r;
        bus_t        b;
        int          due;
        @(negedge clk);
        cyc++;
        rst          = 1'b0;
        jv           = roll(p_jmp);
        bv           = roll(p_br);
        jump_vld     = jv;
        branch_vld   = bv;
        jump_pc      = $urandom & 32'h0000_3FFF;
        branch_pc    = $urandom & 32'h0000_3FFF;
        instr_rdy    = roll(p_rdy);
        imem_req_ack = roll(p_ack);
        resp         = (bq.size() > 0) && (bq[0].due <= cyc);
        imem_resp    = resp;
        imem_rdata   = resp ? bq[0].data : {$urandom, $urandom};
        imem_err     = resp ? bq[0].err : roll(50);
        #1;
        reload = jv | bv;
        rpc    = (jv ? jump_pc : branch_pc) & ~32'h1;
        fa     = reload ? rpc : m_pc;
        ea     = fa & ~32'(BEAT - 1);
        ereq   = (oq.size() < OUTSTD) && ((oq.size() + (reload ? 0 : fq.size())) < QDEPTH)
                 && (!m_err_hold || reload);
        evld   = (fq.size() > 0);
        check_val("imem_req", imem_req, ereq);
        check_val("imem_addr", imem_addr, ea);
        check_val("instr_vld", instr_vld, evld);
        if (evld) begin
            check_val("instr_data", instr_data, fq[0].data);
            check_val("instr_err", instr_err, fq[0].err);
`ifdef INSTR_PREFETCH_PC_EN
            check_val("instr_pc", instr_pc, fq[0].pc);
`endif
        end else begin
            check_val("instr_err_idle", instr_err, 1'b0);
        end
        if (imem_req && imem_req_ack) n_acc++;
        // advance the model across the coming edge
        acc  = ereq && imem_req_ack;
        live = 1'b0;
        if (resp) begin
            r    = oq.pop_front();
            b    = bq.pop_front();
            live = !r.stale && !reload;
        end
        pop = evld && instr_rdy && !reload;
        if (reload) begin
            fq.delete();
            foreach (oq[i]) oq[i].stale = 1'b1;
            m_err_hold = 1'b0;
        end else if (pop) begin
            void'(fq.pop_front());
        end
        if (acc) begin
            oq.push_back('{pc: fa, stale: 1'b0});
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            bq.push_back('{due: due, err: roll(p_err), data: {$urandom, $urandom}});
            m_pc = ea + 32'(BEAT);
        end else if (reload) begin
            m_pc = rpc;
        end
        if (live) begin
            fq.push_back('{pc: r.pc, err: b.err, data: b.data});
            if (b.err) begin
                m_err_hold = 1'b1;
                foreach (oq[i]) oq[i].stale = 1'b1;
            end
        end
    endtask

    task automatic set_knobs(input int ack, input int rdy, input int jmp, input int br,
                             input int err, input int lmin, input int lmax);
        p_ack = ack; p_rdy = rdy; p_jmp = jmp; p_br = br; p_err = err;
        lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; n_acc = 0;
        do_reset();
        // streaming: full ack, 2-cycle latency, always ready
        set_knobs(100, 100, 0, 0, 0, 2, 2);
        repeat (24) cycle();
        // consumer stalled: the FIFO reservation caps issue
        do_reset();
        set_knobs(100, 0, 0, 0, 0, 1, 3);
        n_acc = 0;
        repeat (14) cycle();
        check_val("fill_reqs", n_acc, QDEPTH);
        set_knobs(100, 100, 0, 0, 0, 1, 3);
        repeat (10) cycle();
        // mixed random traffic with redirects and errors
        set_knobs(70, 60, 4, 4, 6, 1, 4);
        repeat (1500) cycle();
        // reset in the middle of a burst, then heavy redirect traffic
        set_knobs(100, 100, 0, 0, 0, 1, 3);
        repeat (6) cycle();
        do_reset();
        set_knobs(80, 70, 20, 20, 8, 1, 3);
        repeat (600) cycle();
        // errors without redirects: the prefetcher must stay silent
        set_knobs(90, 80, 0, 0, 30, 1, 4);
        repeat (60) cycle();
        set_knobs(90, 80, 0, 3, 20, 1, 4);
        repeat (300) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
